prog_loader: RTL and testbench

//  Boot-time program loader upstream of the single-cycle core.

---
 rtl/prog_loader.sv | 136 +++++++++++++
 tb/tb_prog_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a checksummed byte-stream image, packs byte pairs
// into 16-bit words, writes them to instruction memory, then releases the core from reset.
module prog_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMO_W = 32;

  typedef enum logic [2:0] {
    S_COUNT,
    S_HI,
    S_LO,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   n_words, n_words_d;
  logic [CNT_W-1:0]   word_idx, word_idx_d;
  logic [7:0]         hi_byte, hi_byte_d;
  logic [7:0]         xor_acc, xor_acc_d;
  logic [TMO_W-1:0]   tmo_ctr, tmo_ctr_d;
  logic               ready_d, we_d, core_reset_d, done_d, err_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [15:0]        wdata_d;
  logic               xfer, tmo_hit;
  logic [CNT_W-1:0]   idx_inc;

  assign xfer    = rx_valid & rx_ready;
  assign idx_inc = word_idx + CNT_W'(1);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_ctr == TMO_W'(TIMEOUT - 1));

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_COUNT;
      n_words    <= '0;
      word_idx   <= '0;
      hi_byte    <= '0;
      xor_acc    <= '0;
      tmo_ctr    <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_d;
      n_words    <= n_words_d;
      word_idx   <= word_idx_d;
      hi_byte    <= hi_byte_d;
      xor_acc    <= xor_acc_d;
      tmo_ctr    <= tmo_ctr_d;
      rx_ready   <= ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_reset <= core_reset_d;
      load_done  <= done_d;
      load_err   <= err_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state;
    n_words_d  = n_words;
    word_idx_d = word_idx;
    hi_byte_d  = hi_byte;
    xor_acc_d  = xor_acc;
    tmo_ctr_d  = tmo_ctr;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;

    case (state)
      S_COUNT: begin
        tmo_ctr_d = '0;
        if (xfer) begin
          // COUNT of zero selects a full memory image
          n_words_d  = (rx_byte == 8'd0) ? CNT_W'(2 ** ADDR_W) : CNT_W'(rx_byte);
          xor_acc_d  = rx_byte;
          word_idx_d = '0;
          state_d    = S_HI;
        end
      end
      S_HI, S_LO, S_CSUM: begin
        if (xfer) begin
          tmo_ctr_d = '0;
          xor_acc_d = xor_acc ^ rx_byte;
          if (state == S_HI) begin
            hi_byte_d = rx_byte;
            state_d   = S_LO;
          end else if (state == S_LO) begin
            we_d       = 1'b1;
            addr_d     = word_idx[ADDR_W-1:0];
            wdata_d    = {hi_byte, rx_byte};
            word_idx_d = idx_inc;
            state_d    = (idx_inc == n_words) ? S_CSUM : S_HI;
          end else begin
            state_d = (rx_byte == xor_acc) ? S_RUN : S_ERR;
          end
        end else if (tmo_hit) begin
          state_d = S_ERR;
        end else if (TIMEOUT != 0) begin
          tmo_ctr_d = tmo_ctr + TMO_W'(1);
        end
      end
      default: state_d = state;
    endcase

    ready_d      = (state_d == S_COUNT) || (state_d == S_HI) ||
                   (state_d == S_LO)    || (state_d == S_CSUM);
    core_reset_d = (state_d != S_RUN);
    done_d       = (state_d == S_RUN);
    err_d        = (state_d == S_ERR);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: one instance with timeout disabled, one with TIMEOUT=10,
// both driven by the same stream; an imem model captures writes from the first instance.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  logic        rdy0, we0, crst0, done0, err0;
  logic [7:0]  addr0;
  logic [15:0] wdata0;
  logic        rdy1, we1, crst1, done1, err1;
  logic [7:0]  addr1;
  logic [15:0] wdata1;

  int vectors = 0;
  int errs    = 0;

  logic [15:0] mem0 [256];
  int          wcnt0 = 0;
  logic [7:0]  last_addr0 = 8'h00;
  logic        zero_after_ff = 1'b0;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(8), .TIMEOUT(0)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rdy0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
    .core_reset(crst0), .load_done(done0), .load_err(err0)
  );

  prog_loader #(.ADDR_W(8), .TIMEOUT(10)) dut_t (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .core_reset(crst1), .load_done(done1), .load_err(err1)
  );

  // Instruction memory model for the untimed instance
  always @(posedge clk) begin
    if (we0) begin
      mem0[addr0] = wdata0;
      if (addr0 == 8'h00 && last_addr0 == 8'hFF) zero_after_ff = 1'b1;
      last_addr0 = addr0;
      wcnt0++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_model();
    for (int i = 0; i < 256; i++) mem0[i] = 16'h0000;
    wcnt0 = 0;
    last_addr0 = 8'h00;
    zero_after_ff = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Idle cycles (junk on rx_byte) then one transfer; returns 1 ns after the transfer edge
  task automatic send(input logic [7:0] b, input int idle);
    for (int i = 0; i < idle; i++) begin
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_t1(input logic [7:0] csum, input int max_idle);
    send(8'h02, $urandom_range(0, max_idle));
    send(8'h12, $urandom_range(0, max_idle));
    send(8'h34, $urandom_range(0, max_idle));
    send(8'hAB, $urandom_range(0, max_idle));
    send(8'hCD, $urandom_range(0, max_idle));
    send(csum,  $urandom_range(0, max_idle));
  endtask

  initial begin
    clr_model();
    do_reset();
    chk("rst_ready",      32'(rdy0),   32'h1);
    chk("rst_we",         32'(we0),    32'h0);
    chk("rst_addr",       32'(addr0),  32'h0);
    chk("rst_wdata",      32'(wdata0), 32'h0);
    chk("rst_core_reset", 32'(crst0),  32'h1);
    chk("rst_done",       32'(done0),  32'h0);
    chk("rst_err",        32'(err0),   32'h0);

    // T1: two words, CSUM 02^12^34^AB^CD = 42
    send(8'h02, 0);
    send(8'h12, 0);
    chk("t1_no_we_after_hi", 32'(we0), 32'h0);
    send(8'h34, 0);
    chk("t1_we_word0",    32'(we0),    32'h1);
    chk("t1_addr_word0",  32'(addr0),  32'h00);
    chk("t1_wdata_word0", 32'(wdata0), 32'h1234);
    send(8'hAB, 0);
    chk("t1_we_pulse_1cyc", 32'(we0),    32'h0);
    chk("t1_wdata_held",    32'(wdata0), 32'h1234);
    send(8'hCD, 0);
    chk("t1_addr_word1",  32'(addr0),  32'h01);
    chk("t1_core_rst_pre", 32'(crst0), 32'h1);
    send(8'h42, 0);
    chk("t1_we_in_run",   32'(we0),     32'h0);
    chk("t1_mem0",        32'(mem0[0]), 32'h1234);
    chk("t1_mem1",        32'(mem0[1]), 32'hABCD);
    chk("t1_wcnt",        32'(wcnt0),   32'd2);
    chk("t1_core_reset",  32'(crst0),   32'h0);
    chk("t1_done",        32'(done0),   32'h1);
    chk("t1_ready_run",   32'(rdy0),    32'h0);
    chk("t1_err",         32'(err0),    32'h0);

    // Reset from S_RUN re-arms the loader
    do_reset();
    chk("rerun_core_reset", 32'(crst0), 32'h1);
    chk("rerun_done",       32'(done0), 32'h0);
    chk("rerun_ready",      32'(rdy0),  32'h1);

    // T2: bad checksum
    clr_model();
    send_t1(8'h43, 0);
    chk("t2_wcnt",       32'(wcnt0),   32'd2);
    chk("t2_mem1",       32'(mem0[1]), 32'hABCD);
    chk("t2_err",        32'(err0),    32'h1);
    chk("t2_core_reset", 32'(crst0),   32'h1);
    chk("t2_ready",      32'(rdy0),    32'h0);
    chk("t2_done",       32'(done0),   32'h0);

    // T3: N=0 -> 256 words, word i = {i, i^5A}; all bytes XOR to 00
    do_reset();
    clr_model();
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'(i), 0);
      send(8'(i) ^ 8'h5A, 0);
    end
    send(8'h00, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("t3_wcnt",      32'(wcnt0),         32'd256);
    chk("t3_last_addr", 32'(last_addr0),    32'hFF);
    chk("t3_no_wrap",   32'(zero_after_ff), 32'h0);
    chk("t3_mem00",     32'(mem0[0]),       32'h005A);
    chk("t3_mem80",     32'(mem0[128]),     32'h80DA);
    chk("t3_memFF",     32'(mem0[255]),     32'hFFA5);
    chk("t3_done",      32'(done0),         32'h1);
    chk("t3_done_tmo",  32'(done1),         32'h1);

    // T4: stall of 10 idle cycles after the hi byte trips the timeout
    do_reset();
    send(8'h02, 0);
    send(8'h12, 0);
    rx_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("t4_no_err_at_9",   32'(err1), 32'h0);
    @(posedge clk);
    #1;
    chk("t4_err_at_10",     32'(err1),  32'h1);
    chk("t4_ready_err",     32'(rdy1),  32'h0);
    chk("t4_core_rst_err",  32'(crst1), 32'h1);
    chk("t4_untimed_no_err", 32'(err0), 32'h0);
    chk("t4_untimed_ready", 32'(rdy0),  32'h1);

    // T4b: stall of 9 cycles, then resume to completion
    do_reset();
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 9);
    send(8'hAB, 0);
    send(8'hCD, 0);
    send(8'h42, 0);
    chk("t4b_err",  32'(err1),  32'h0);
    chk("t4b_done", 32'(done1), 32'h1);
    chk("t4b_wdata", 32'(wdata1), 32'hABCD);

    // T5: reset lands on the edge that would have transferred the lo byte
    do_reset();
    clr_model();
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'hAB, 0);
    rx_valid = 1'b1;
    rx_byte  = 8'hCD;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_we_dropped",  32'(we0),    32'h0);
    chk("t5_wcnt_mid",    32'(wcnt0),  32'd1);
    chk("t5_wdata_rst",   32'(wdata0), 32'h0);
    chk("t5_core_reset",  32'(crst0),  32'h1);
    reset    = 1'b0;
    rx_valid = 1'b0;
    clr_model();
    send_t1(8'h42, 0);
    chk("t5_mem0",  32'(mem0[0]), 32'h1234);
    chk("t5_mem1",  32'(mem0[1]), 32'hABCD);
    chk("t5_wcnt",  32'(wcnt0),   32'd2);
    chk("t5_done",  32'(done0),   32'h1);
    chk("t5_crst",  32'(crst0),   32'h0);

    // T6: random 0-3 idle cycles per byte with junk on rx_byte
    do_reset();
    clr_model();
    send_t1(8'h42, 3);
    chk("t6_mem0", 32'(mem0[0]), 32'h1234);
    chk("t6_mem1", 32'(mem0[1]), 32'hABCD);
    chk("t6_wcnt", 32'(wcnt0),   32'd2);
    chk("t6_done", 32'(done0),   32'h1);
    chk("t6_err",  32'(err0),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
